// File: rtl/reg_dump_engine_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : reg_dump_engine_if
//  Description : Record stream carrying {index, value, cycle tag, last} from
//                the register dump engine to its consumer (valid/ready).
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_dump_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CYC_W  = 16
);
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_idx;
    logic [DATA_W-1:0] dump_data;
    logic [CYC_W-1:0]  dump_cycle;
    logic              dump_last;

    // Engine side: produces records, observes back-pressure.
    modport master (
        output dump_valid,
        output dump_idx,
        output dump_data,
        output dump_cycle,
        output dump_last,
        input  dump_ready
    );

    // Consumer side: observes records, drives back-pressure.
    modport slave (
        input  dump_valid,
        input  dump_idx,
        input  dump_data,
        input  dump_cycle,
        input  dump_last,
        output dump_ready
    );
endinterface
`default_nettype wire

// File: rtl/reg_dump_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : reg_dump_engine
//  Description : Walks a (possibly wrapping) range of register-file entries
//                through a spare read port and streams one record per entry,
//                each tagged with the cycle count captured at dump start.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CYC_W  = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] first_idx,
    input  wire logic [ADDR_W-1:0] last_idx,
    output logic                   busy,
    output logic [ADDR_W-1:0]      rf_raddr,
    input  wire logic [DATA_W-1:0] rf_rdata,
    reg_dump_engine_if.master      dump,
    output logic                   done
);

    localparam logic [ADDR_W-1:0] c_idx_inc = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0]  c_cnt_inc = {{(CYC_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Single-cycle action strobes decoded from the FSM.
    logic              w_accept;     // dump request taken in IDLE
    logic              w_capture;    // read port sampled into the record
    logic              w_handshake;  // record consumed
    logic              w_finish;     // DONE cycle, engine returns to IDLE

    logic [CYC_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_last_idx;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_data;
    logic [CYC_W-1:0]  r_cycle;
    logic              r_valid;
    logic              r_last;
    logic              r_busy;
    logic              r_done;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and action decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_handshake = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (r_valid && dump.dump_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = r_last ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                // start is not looked at here, so a request coinciding with
                // the done pulse is dropped rather than queued.
                w_finish    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Free-running cycle counter; wraps naturally at 2^CYC_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_inc;
        end
    end

    // Range walker: the index increment wraps through zero, which is what
    // makes a first > last range cover first..top, 0..last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur      <= '0;
            r_last_idx <= '0;
        end else if (w_accept) begin
            r_cur      <= first_idx;
            r_last_idx <= last_idx;
        end else if (w_handshake && !r_last) begin
            r_cur      <= r_cur + c_idx_inc;
        end
    end

    // Record register: loaded in READ, held stable while back-pressured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
            r_cycle <= '0;
        end else begin
            if (w_accept) begin
                r_cycle <= r_cnt;
            end
            if (w_capture) begin
                r_idx   <= r_cur;
                r_data  <= rf_rdata;
                r_last  <= (r_cur == r_last_idx);
                r_valid <= 1'b1;
            end else if (w_handshake) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Status: busy spans acceptance through the done cycle; done pulses once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (w_finish) begin
                r_busy <= 1'b0;
            end
            r_done <= w_handshake && r_last;
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign rf_raddr        = r_cur;
    assign dump.dump_valid = r_valid;
    assign dump.dump_idx   = r_idx;
    assign dump.dump_data  = r_data;
    assign dump.dump_cycle = r_cycle;
    assign dump.dump_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_reg_dump_engine
//  Description : Self-checking bench for reg_dump_engine: transaction-level
//                model with a per-cycle compare plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_dump_engine;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CYC_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] first_idx = '0;
    logic [ADDR_W-1:0] last_idx = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic [DATA_W-1:0] rf [32];

    reg_dump_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CYC_W(CYC_W)) dif ();

    assign rf_rdata = rf[rf_raddr];

    reg_dump_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CYC_W(CYC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .busy      (busy),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .dump      (dif.master),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        last;
        logic [15:0] cyc;
    } rec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    rec_t        cap [$];

    // Transaction-level model: expected record sequence and coarse timing.
    bit          m_busy, m_valid, m_pend, m_done;
    int          m_q [$];
    logic [15:0] m_cnt, m_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model by one clock.
    task automatic model_step();
        int i;
        if (reset) begin
            chk("rst_busy", busy, 0);
            chk("rst_valid", dif.dump_valid, 0);
            chk("rst_done", done, 0);
            chk("rst_idx", dif.dump_idx, 0);
            chk("rst_data", dif.dump_data, 0);
            chk("rst_cycle", dif.dump_cycle, 0);
            chk("rst_last", dif.dump_last, 0);
            m_busy = 0; m_valid = 0; m_pend = 0; m_done = 0;
            m_q.delete();
            m_cnt = '0;
        end else begin
            chk("busy", busy, m_busy);
            chk("dump_valid", dif.dump_valid, m_valid);
            chk("done", done, m_done);
            if (m_pend) chk("rf_raddr", rf_raddr, m_q[0]);
            if (m_valid) begin
                chk("dump_idx", dif.dump_idx, m_q[0]);
                chk("dump_data", dif.dump_data, rf[m_q[0]]);
                chk("dump_last", dif.dump_last, m_q.size() == 1);
                chk("dump_cycle", dif.dump_cycle, m_cyc);
            end
            if (done) done_cnt++;
            if (dif.dump_valid && dif.dump_ready)
                cap.push_back('{idx: int'(dif.dump_idx), data: dif.dump_data,
                                last: dif.dump_last, cyc: dif.dump_cycle});
            if (m_done) begin
                m_done = 0;
                m_busy = 0;
            end else if (!m_busy) begin
                if (start) begin
                    i = int'(first_idx);
                    forever begin
                        m_q.push_back(i);
                        if (i == int'(last_idx)) break;
                        i = (i + 1) % 32;
                    end
                    m_cyc  = m_cnt;
                    m_busy = 1;
                    m_pend = 1;
                end
            end else if (m_pend) begin
                m_pend  = 0;
                m_valid = 1;
            end else if (m_valid && dif.dump_ready) begin
                m_valid = 0;
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1;
                else m_pend = 1;
            end
            m_cnt = m_cnt + 16'd1;
        end
    endtask

    // One clock: model/compare at negedge, return 1ns after the rising edge.
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump(input int f, input int l);
        first_idx = ADDR_W'(f);
        last_idx  = ADDR_W'(l);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < budget) begin
            tick();
            k++;
        end
        chk("done_pulses", done_cnt - d0, 1);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!dif.dump_valid && k < budget) begin
            tick();
            k++;
        end
        chk("valid_seen", dif.dump_valid, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp2 [4];
        dif.dump_ready = 1'b1;
        for (int r = 0; r < 32; r++) rf[r] = 32'hA500_0000 | (r * 32'h0001_0101);
        rf[16] = 32'h11; rf[17] = 32'h22; rf[18] = 32'h33;
        #1;
        do_reset();
        chk("init_busy", busy, 0);
        chk("init_valid", dif.dump_valid, 0);

        // Test 1: simple ascending range with consumer always ready.
        cap.delete();
        start_dump(16, 18);
        chk("t1_busy", busy, 1);
        chk("t1_lat0", dif.dump_valid, 0);
        tick();
        chk("t1_lat1", dif.dump_valid, 1);
        wait_done(40);
        chk("t1_count", cap.size(), 3);
        if (cap.size() == 3) begin
            chk("t1_idx0", cap[0].idx, 16);  chk("t1_data0", cap[0].data, 32'h11);
            chk("t1_idx1", cap[1].idx, 17);  chk("t1_data1", cap[1].data, 32'h22);
            chk("t1_idx2", cap[2].idx, 18);  chk("t1_data2", cap[2].data, 32'h33);
            chk("t1_last0", cap[0].last, 0); chk("t1_last1", cap[1].last, 0);
            chk("t1_last2", cap[2].last, 1);
        end
        tick();
        chk("t1_idle", busy, 0);

        // Test 2: wrapping range 30..1.
        rf[0] = 32'h0; rf[30] = 32'h3030; rf[31] = 32'h3131; rf[1] = 32'h0101;
        exp2 = '{30, 31, 0, 1};
        cap.delete();
        start_dump(30, 1);
        wait_done(60);
        chk("t2_count", cap.size(), 4);
        if (cap.size() == 4) begin
            for (int j = 0; j < 4; j++) begin
                chk("t2_idx", cap[j].idx, exp2[j]);
                chk("t2_last", cap[j].last, j == 3);
            end
            chk("t2_reg0", cap[2].data, 0);
            chk("t2_reg31", cap[1].data, 32'h3131);
        end
        tick();

        // Test 3: single-entry range with back-pressure.
        dif.dump_ready = 1'b0;
        cap.delete();
        start_dump(8, 8);
        wait_valid(10);
        for (int j = 0; j < 5; j++) begin
            chk("t3_hold_valid", dif.dump_valid, 1);
            chk("t3_hold_idx", dif.dump_idx, 8);
            chk("t3_hold_data", dif.dump_data, 32'hA508_0808);
            chk("t3_hold_last", dif.dump_last, 1);
            chk("t3_no_done", done, 0);
            tick();
        end
        dif.dump_ready = 1'b1;
        tick();
        chk("t3_done_next", done, 1);
        chk("t3_valid_drop", dif.dump_valid, 0);
        tick();
        chk("t3_done_once", done, 0);
        chk("t3_count", cap.size(), 1);
        tick();
        chk("t3_idle", busy, 0);

        // Test 4: cycle tag snapshot and start-while-busy ignored.
        do_reset();
        while (m_cnt != 16'd100) tick();
        cap.delete();
        start_dump(4, 6);
        tick();
        first_idx = 5'd10; last_idx = 5'd12; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(40);
        chk("t4_count", cap.size(), 3);
        if (cap.size() == 3) begin
            for (int j = 0; j < 3; j++) begin
                chk("t4_cycle", cap[j].cyc, 100);
                chk("t4_idx", cap[j].idx, 4 + j);
            end
        end
        repeat (5) tick();
        chk("t4_no_restart", busy, 0);
        chk("t4_count_after", cap.size(), 3);

        // Test 5: asynchronous reset while a record is pending.
        dif.dump_ready = 1'b0;
        start_dump(0, 31);
        wait_valid(10);
        #1 reset = 1'b1;
        #1;
        chk("t5_async_valid", dif.dump_valid, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_done", done, 0);
        tick();
        reset = 1'b0;
        dif.dump_ready = 1'b1;
        tick();
        cap.delete();
        start_dump(2, 5);
        wait_done(40);
        chk("t5_count", cap.size(), 4);
        if (cap.size() == 4) begin
            chk("t5_first", cap[0].idx, 2);
            chk("t5_final", cap[3].idx, 5);
        end
        tick();

        // Test 6: register write during the dump is seen by the later read.
        cap.delete();
        start_dump(16, 23);
        rf[20] = 32'hDEAD_BEEF;
        wait_done(60);
        chk("t6_count", cap.size(), 8);
        foreach (cap[j]) begin
            if (cap[j].idx == 20) chk("t6_reg20", cap[j].data, 32'hDEAD_BEEF);
        end
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
